// File: rtl/puzzle_lock_ctrl.sv
// puzzle_lock_ctrl: switch-code puzzle lock. It has a BCD countdown, an attempt
// limit, a pass/fail glyph on the 8x8 matrix, a 4-digit 7-segment readout and
// a beeper.
// Ports:
//   sysclk, rst_n          clock, asynchronous active-low reset
//   check, restart         raw push buttons, active high
//   sw[SW_W]               raw switch word
//   state[2]               0 RUN, 1 PASS, 2 FAIL
//   enable, beep           matrix enable, beeper drive
//   set[3]                 matrix row select
//   DATA_R/G/B[8]          matrix columns, active low
//   seg[7], COM[4]         segments {a..g} and digit enables, active low
module puzzle_lock_ctrl #(
  parameter int unsigned                 SW_W      = 8,
  parameter int unsigned                 NUM_ANS   = 3,
  parameter logic [NUM_ANS*SW_W-1:0]     ANS_TABLE = {8'h5F, 8'h58, 8'hAC},
  parameter logic [SW_W-1:0]             SW_INV    = 8'hF0,
  parameter int unsigned                 START_MIN = 3,
  parameter int unsigned                 START_SEC = 59,
  parameter int unsigned                 MAX_TRY   = 3,
  parameter int unsigned                 TICK_DIV  = 50_000_000,
  parameter int unsigned                 SCAN_DIV  = 10_000,
  parameter int unsigned                 BEEP_CYC  = 5_000_000
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            check,
  input  logic            restart,
  input  logic [SW_W-1:0] sw,
  output logic [1:0]      state,
  output logic            enable,
  output logic            beep,
  output logic [2:0]      set,
  output logic [7:0]      DATA_R,
  output logic [7:0]      DATA_G,
  output logic [7:0]      DATA_B,
  output logic [6:0]      seg,
  output logic [3:0]      COM
);

  localparam int unsigned TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SDW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BCW = $clog2(BEEP_CYC + 1);

  localparam logic [3:0]     MIN_INIT   = 4'(START_MIN);
  localparam logic [2:0]     SEC_T_INIT = 3'(START_SEC / 10);
  localparam logic [3:0]     SEC_U_INIT = 4'(START_SEC % 10);
  localparam logic [3:0]     TRY_INIT   = 4'(MAX_TRY);
  localparam logic [TDW-1:0] TICK_LAST  = TDW'(TICK_DIV - 1);
  localparam logic [SDW-1:0] SCAN_LAST  = SDW'(SCAN_DIV - 1);
  localparam logic [BCW-1:0] BEEP_LOAD  = BCW'(BEEP_CYC);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  // 7-segment pattern for a decimal digit, active low {a..g}
  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    seg_enc = 7'h01;
      4'd1:    seg_enc = 7'h4F;
      4'd2:    seg_enc = 7'h12;
      4'd3:    seg_enc = 7'h06;
      4'd4:    seg_enc = 7'h4C;
      4'd5:    seg_enc = 7'h24;
      4'd6:    seg_enc = 7'h60;
      4'd7:    seg_enc = 7'h0D;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h0C;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  // Pass glyph row
  function automatic logic [7:0] circle_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: circle_row = 8'hFF;
      3'd1, 3'd6: circle_row = 8'hC3;
      default:    circle_row = 8'hBD;
    endcase
  endfunction

  // Fail glyph row
  function automatic logic [7:0] cross_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: cross_row = 8'h7E;
      3'd1, 3'd6: cross_row = 8'hBD;
      3'd2, 3'd5: cross_row = 8'hDB;
      default:    cross_row = 8'hE7;
    endcase
  endfunction

  // Synchronisers and edge detect; buttons reset as "pressed" so a button
  // held through reset must be released before it can generate a pulse.
  logic [2:0]      chk_sync_q, rst_sync_q;
  logic            chk_pulse_q, rst_pulse_q;
  logic [SW_W-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sync_q  <= 3'b111;
      rst_sync_q  <= 3'b111;
      chk_pulse_q <= 1'b0;
      rst_pulse_q <= 1'b0;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
    end else begin
      chk_sync_q  <= {chk_sync_q[1:0], check};
      rst_sync_q  <= {rst_sync_q[1:0], restart};
      chk_pulse_q <= chk_sync_q[1] & ~chk_sync_q[2];
      rst_pulse_q <= rst_sync_q[1] & ~rst_sync_q[2];
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
    end
  end

  // Answer match against every table entry
  logic match_c;
  always_comb begin
    match_c = 1'b0;
    for (int unsigned k = 0; k < NUM_ANS; k++) begin
      if ((sw_s2_q ^ SW_INV) == ANS_TABLE[k*SW_W +: SW_W]) match_c = 1'b1;
    end
  end

  state_e         state_q, state_d;
  logic [3:0]     min_q, min_d, sec_u_q, sec_u_d, tries_q, tries_d;
  logic [2:0]     sec_t_q, sec_t_d;
  logic [TDW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SDW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BCW-1:0] beep_cnt_q, beep_cnt_d;
  logic [2:0]     row_q, row_d;
  logic [1:0]     dig_q, dig_d;
  logic           tick_c, scan_c, timer_zero_c, beep_load;
  logic [7:0]     data_r_d, data_g_d;
  logic [6:0]     seg_d;
  logic [3:0]     com_d;

  assign tick_c       = (tick_cnt_q == TICK_LAST);
  assign scan_c       = (scan_cnt_q == SCAN_LAST);
  assign timer_zero_c = (min_q == 4'd0) && (sec_t_q == 3'd0) && (sec_u_q == 4'd0);

  // Game FSM: next state, timer, tries, dividers and beep counter
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_t_d    = sec_t_q;
    sec_u_d    = sec_u_q;
    tries_d    = tries_q;
    beep_load  = 1'b0;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TDW'(1);
    beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - BCW'(1) : beep_cnt_q;

    if (rst_pulse_q) begin
      state_d    = ST_RUN;
      min_d      = MIN_INIT;
      sec_t_d    = SEC_T_INIT;
      sec_u_d    = SEC_U_INIT;
      tries_d    = TRY_INIT;
      tick_cnt_d = '0;
      beep_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (chk_pulse_q && match_c) begin
        // A correct answer wins over a coincident final tick
        state_d   = ST_PASS;
        beep_load = 1'b1;
      end else begin
        if (chk_pulse_q) begin
          tries_d   = tries_q - 4'd1;
          beep_load = 1'b1;
          if (tries_q == 4'd1) state_d = ST_FAIL;
        end
        if (tick_c) begin
          if (timer_zero_c) begin
            state_d   = ST_FAIL;
            beep_load = 1'b1;
          end else if (state_d == ST_RUN) begin
            // BCD decrement with borrow chain su -> st -> min
            if (sec_u_q != 4'd0) begin
              sec_u_d = sec_u_q - 4'd1;
            end else begin
              sec_u_d = 4'd9;
              if (sec_t_q != 3'd0) begin
                sec_t_d = sec_t_q - 3'd1;
              end else begin
                sec_t_d = 3'd5;
                if (min_q != 4'd0) min_d = min_q - 4'd1;
              end
            end
          end
        end
      end
    end

    if (beep_load) beep_cnt_d = BEEP_LOAD;
  end

  // Scan position: digit always cycles; matrix row only runs outside RUN
  always_comb begin
    scan_cnt_d = scan_c ? '0 : scan_cnt_q + SDW'(1);
    dig_d      = scan_c ? dig_q + 2'd1 : dig_q;
    row_d      = row_q;
    if (rst_pulse_q || (state_q == ST_RUN)) row_d = 3'd0;
    else if (scan_c)                        row_d = row_q + 3'd1;
  end

  // Display data from next-cycle values so row/digit and content stay aligned
  always_comb begin
    data_r_d = 8'hFF;
    data_g_d = 8'hFF;
    if (state_d == ST_PASS) data_g_d = circle_row(row_d);
    if (state_d == ST_FAIL) data_r_d = cross_row(row_d);
    com_d = ~(4'b0001 << dig_d);
    case (dig_d)
      2'd0:    seg_d = seg_enc(min_d);
      2'd1:    seg_d = seg_enc({1'b0, sec_t_d});
      2'd2:    seg_d = seg_enc(sec_u_d);
      default: seg_d = seg_enc(tries_d);
    endcase
  end

  // State and counter registers
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      min_q      <= MIN_INIT;
      sec_t_q    <= SEC_T_INIT;
      sec_u_q    <= SEC_U_INIT;
      tries_q    <= TRY_INIT;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      beep_cnt_q <= '0;
      row_q      <= 3'd0;
      dig_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_t_q    <= sec_t_d;
      sec_u_q    <= sec_u_d;
      tries_q    <= tries_d;
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      beep_cnt_q <= beep_cnt_d;
      row_q      <= row_d;
      dig_q      <= dig_d;
    end
  end

  // Output registers
  logic       enable_q, beep_q;
  logic [7:0] data_r_q, data_g_q, data_b_q;
  logic [6:0] seg_q;
  logic [3:0] com_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b1;
      beep_q   <= 1'b0;
      data_r_q <= 8'hFF;
      data_g_q <= 8'hFF;
      data_b_q <= 8'hFF;
      seg_q    <= 7'h7F;
      com_q    <= 4'hF;
    end else begin
      enable_q <= 1'b1;
      beep_q   <= (beep_cnt_d != '0);
      data_r_q <= data_r_d;
      data_g_q <= data_g_d;
      data_b_q <= 8'hFF;
      seg_q    <= seg_d;
      com_q    <= com_d;
    end
  end

  assign state  = state_q;
  assign enable = enable_q;
  assign beep   = beep_q;
  assign set    = row_q;
  assign DATA_R = data_r_q;
  assign DATA_G = data_g_q;
  assign DATA_B = data_b_q;
  assign seg    = seg_q;
  assign COM    = com_q;

endmodule
